vmul_sew_seq: RTL and testbench

VMUL_SEW_SEQ -- requirements
Module: vmul_sew_seq

---
 rtl/vmul_sew_seq.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_vmul_sew_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmul_sew_seq.sv
// vmul_sew_seq: sequential SEW-configurable vector integer multiplier.
//
// Multiplies packed elements of data_in_A and data_in_B (8/16/32-bit
// elements, element 0 in the LSBs). The multiply uses DATA_W/8 8x8
// partial-product multipliers over N cycles (N = 1/2/4 for SEW 8/16/32).
// Each cycle multiplies one A byte of every element by all B bytes of that
// element, and the shifted products are summed into an accumulator.
// The unsigned product is then sign-corrected for vmulh/vmulhsu.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   data_in_A, data_in_B  packed operand vectors
//   sew                   00=8, 01=16, 10=32, 11=illegal
//   op                    00=vmul, 01=vmulh, 10=vmulhu, 11=vmulhsu
//   out_valid / out_ready result handshake (valid only in DONE)
//   result                per-element result, 0 while out_valid=0
//   result_wide           full 2*SEW products (only with VMUL_WIDEN_EN)
//   illegal               accepted sew was 11
//   busy                  state is not IDLE
//
// Optional feature macro: VMUL_WIDEN_EN adds the result_wide output.
module vmul_sew_seq #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   data_in_A,
  input  logic [DATA_W-1:0]   data_in_B,
  input  logic [1:0]          sew,
  input  logic [1:0]          op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   result,
`ifdef VMUL_WIDEN_EN
  output logic [2*DATA_W-1:0] result_wide,
`endif
  output logic                illegal,
  output logic                busy
);

  localparam int NB = DATA_W / 8;
  localparam int PW = 2 * DATA_W;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;
  localparam logic [1:0] SEW_BAD = 2'b11;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [1:0]        cnt_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [1:0]        sew_r;
  logic [1:0]        op_r;
  logic [PW-1:0]     acc_r;
  logic [DATA_W-1:0] result_r;
  logic              illegal_r;
`ifdef VMUL_WIDEN_EN
  logic [PW-1:0]     wide_r;
`endif

  logic [PW-1:0]     pp_sum_s;
  logic [DATA_W-1:0] a_sh_s;
  logic [15:0]       pp_s;
  int                a_idx_s;
  int                sh_s;
  logic              pp_en_s;

  logic [PW-1:0]     prod_raw_s;
  logic [PW-1:0]     prod_s;
  logic [DATA_W-1:0] res_s;
  logic              sgn_a_s;
  logic              sgn_b_s;
  logic [7:0]        h8_s;
  logic [15:0]       h16_s;
  logic [31:0]       h32_s;

  // Number of COMPUTE cycles minus one for a given element width.
  function automatic logic [1:0] cycles_m1(input logic [1:0] s);
    case (s)
      SEW_16:  return 2'd1;
      SEW_32:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Partial products for this cycle: multiplier k handles B byte k against
  // A byte cnt_r of the same element (SEW 8 needs only one cycle).
  always_comb begin
    pp_sum_s = '0;
    a_sh_s   = '0;
    pp_s     = '0;
    a_idx_s  = 0;
    sh_s     = 0;
    pp_en_s  = 1'b0;
    for (int k = 0; k < NB; k++) begin
      case (sew_r)
        SEW_8: begin
          a_idx_s = k;
          sh_s    = 16 * k;
          pp_en_s = 1'b1;
        end
        SEW_16: begin
          a_idx_s = (k / 2) * 2 + int'(cnt_r);
          sh_s    = 32 * (k / 2) + 8 * ((k % 2) + int'(cnt_r));
          pp_en_s = 1'b1;
        end
        SEW_32: begin
          a_idx_s = (k / 4) * 4 + int'(cnt_r);
          sh_s    = 64 * (k / 4) + 8 * ((k % 4) + int'(cnt_r));
          pp_en_s = 1'b1;
        end
        default: begin
          a_idx_s = 0;
          sh_s    = 0;
          pp_en_s = 1'b0;
        end
      endcase
      a_sh_s = a_r >> (8 * a_idx_s);
      pp_s   = {8'd0, a_sh_s[7:0]} * {8'd0, b_r[8*k +: 8]};
      if (pp_en_s) begin
        pp_sum_s = pp_sum_s + ({{(PW-16){1'b0}}, pp_s} << sh_s);
      end else begin
        pp_sum_s = pp_sum_s;
      end
    end
  end

  // Final product and result selection. The high half of an unsigned
  // product becomes signed by subtracting B (if A negative) and A (if B
  // negative) modulo 2^SEW; doing it per element keeps borrows local.
  always_comb begin
    prod_raw_s = acc_r + pp_sum_s;
    prod_s     = prod_raw_s;
    res_s      = '0;
    h8_s       = '0;
    h16_s      = '0;
    h32_s      = '0;
    sgn_a_s    = (op_r == OP_MULH) || (op_r == OP_MULHSU);
    sgn_b_s    = (op_r == OP_MULH);
    case (sew_r)
      SEW_8: begin
        for (int e = 0; e < NB; e++) begin
          h8_s = prod_raw_s[16*e+8 +: 8]
               - ((sgn_a_s && a_r[8*e+7]) ? b_r[8*e +: 8] : 8'd0)
               - ((sgn_b_s && b_r[8*e+7]) ? a_r[8*e +: 8] : 8'd0);
          prod_s[16*e+8 +: 8] = h8_s;
          res_s[8*e +: 8] = (op_r == OP_MUL) ? prod_raw_s[16*e +: 8] : h8_s;
        end
      end
      SEW_16: begin
        for (int e = 0; e < NB / 2; e++) begin
          h16_s = prod_raw_s[32*e+16 +: 16]
                - ((sgn_a_s && a_r[16*e+15]) ? b_r[16*e +: 16] : 16'd0)
                - ((sgn_b_s && b_r[16*e+15]) ? a_r[16*e +: 16] : 16'd0);
          prod_s[32*e+16 +: 16] = h16_s;
          res_s[16*e +: 16] = (op_r == OP_MUL) ? prod_raw_s[32*e +: 16] : h16_s;
        end
      end
      SEW_32: begin
        for (int e = 0; e < NB / 4; e++) begin
          h32_s = prod_raw_s[64*e+32 +: 32]
                - ((sgn_a_s && a_r[32*e+31]) ? b_r[32*e +: 32] : 32'd0)
                - ((sgn_b_s && b_r[32*e+31]) ? a_r[32*e +: 32] : 32'd0);
          prod_s[64*e+32 +: 32] = h32_s;
          res_s[32*e +: 32] = (op_r == OP_MUL) ? prod_raw_s[64*e +: 32] : h32_s;
        end
      end
      default: begin
        prod_s = '0;
        res_s  = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = COMPUTE;
        end else begin
          state_s = IDLE;
        end
      end
      COMPUTE: begin
        if (cnt_r == 2'd0) begin
          state_s = DONE;
        end else begin
          state_s = COMPUTE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, accumulation and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= 2'd0;
      a_r       <= '0;
      b_r       <= '0;
      sew_r     <= 2'b00;
      op_r      <= 2'b00;
      acc_r     <= '0;
      result_r  <= '0;
      illegal_r <= 1'b0;
`ifdef VMUL_WIDEN_EN
      wide_r    <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r   <= data_in_A;
            b_r   <= data_in_B;
            sew_r <= sew;
            op_r  <= op;
            cnt_r <= cycles_m1(sew);
            acc_r <= '0;
          end
        end
        COMPUTE: begin
          acc_r <= prod_raw_s;
          if (cnt_r == 2'd0) begin
            result_r  <= res_s;
            illegal_r <= (sew_r == SEW_BAD);
`ifdef VMUL_WIDEN_EN
            wide_r    <= prod_s;
`endif
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        DONE: begin
          // Outputs read as zero once the result has been popped.
          if (out_ready) begin
            result_r  <= '0;
            illegal_r <= 1'b0;
`ifdef VMUL_WIDEN_EN
            wide_r    <= '0;
`endif
          end
        end
        default: begin
          acc_r <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = (state_r == DONE);
  assign result    = result_r;
  assign illegal   = illegal_r;
`ifdef VMUL_WIDEN_EN
  assign result_wide = wide_r;
`endif

endmodule

// File: tb/tb_vmul_sew_seq.sv
// Self-checking bench for vmul_sew_seq (DATA_W=32): a vector table driven
// through the handshake, a queue of expected results, and hand-written
// sequences for back-pressure and mid-operation reset.
module tb_vmul_sew_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in_A;
  logic [31:0] data_in_B;
  logic [1:0]  sew;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;
  logic        busy;
`ifdef VMUL_WIDEN_EN
  logic [63:0] result_wide;
`endif

  always #5 clk = ~clk;

  vmul_sew_seq #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in_A (data_in_A),
    .data_in_B (data_in_B),
    .sew       (sew),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef VMUL_WIDEN_EN
    .result_wide(result_wide),
`endif
    .illegal   (illegal),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sew;
    logic [1:0]  op;
    logic [31:0] res;
    logic        ill;
    logic [63:0] wide;
  } vec_t;

  vec_t tbl[18];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [1:0] s);
    return (s == 2'b01) ? 2 : ((s == 2'b10) ? 4 : 1);
  endfunction

  // Reference: native multiply of sign/zero-extended elements.
  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] s, input logic [1:0] o);
    vec_t v;
    int S;
    logic [63:0] ea, eb, p, m1, m2, w;
    logic [31:0] r;
    v.a = a; v.b = b; v.sew = s; v.op = o;
    v.res = 32'd0; v.ill = 1'b0; v.wide = 64'd0;
    if (s == 2'b11) begin
      v.ill = 1'b1;
      return v;
    end
    S  = 8 << s;
    m1 = (64'd1 << S) - 64'd1;
    m2 = (S == 32) ? {64{1'b1}} : ((64'd1 << (2 * S)) - 64'd1);
    r  = 32'd0;
    w  = 64'd0;
    for (int e = 0; e < 32 / S; e++) begin
      ea = (64'(a) >> (S * e)) & m1;
      eb = (64'(b) >> (S * e)) & m1;
      if ((o == 2'b01 || o == 2'b11) && ea[S-1]) ea = ea | ~m1;
      if (o == 2'b01 && eb[S-1]) eb = eb | ~m1;
      p = ea * eb;
      if (o == 2'b00) r = r | 32'((p & m1) << (S * e));
      else            r = r | 32'(((p >> S) & m1) << (S * e));
      w = w | ((p & m2) << (2 * S * e));
    end
    v.res  = r;
    v.wide = w;
    return v;
  endfunction

  // Wait (bounded) for out_valid, check latency and the expected entry.
  task automatic wait_and_check(input int exp_lat);
    int lat;
    vec_t e;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("result", 64'(result), 64'(e.res));
      check("illegal", 64'(illegal), 64'(e.ill));
`ifdef VMUL_WIDEN_EN
      check("result_wide", result_wide, e.wide);
`endif
    end
  endtask

  task automatic pop_check();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("pop_valid", 64'(out_valid), 64'd0);
    check("pop_result", 64'(result), 64'd0);
    check("pop_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic do_op(input vec_t v, input int hold);
    int guard;
    logic [31:0] held;
    exp_q.push_back(v);
    @(negedge clk);
    in_valid = 1'b1; data_in_A = v.a; data_in_B = v.b; sew = v.sew; op = v.op;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    // Scramble inputs after accept; they must not affect the result.
    in_valid  = 1'b0;
    data_in_A = $urandom;
    data_in_B = $urandom;
    sew       = 2'($urandom_range(0, 3));
    op        = 2'($urandom_range(0, 3));
    check("busy_after_accept", 64'(busy), 64'd1);
    wait_and_check(lat_of(v.sew));
    held = result;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_result", 64'(result), 64'(held));
      check("hold_valid", 64'(out_valid), 64'd1);
    end
    pop_check();
  endtask

  initial begin
    vec_t v27, v27b, v28, v28b;
    logic [31:0] held;
    logic seen;

    tbl[0] = mk(32'h11223344, 32'hAABBCCDD, 2'b00, 2'b00);
    tbl[0].res = 32'h4AD6A4B4; tbl[0].wide = 64'h0B4A18D628A43AB4;
    tbl[1] = mk(32'h11223344, 32'hAABBCCDD, 2'b01, 2'b00);
    tbl[1].res = 32'h17D671B4;
    tbl[2] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 2'b10);
    tbl[2].res = 32'hFFFFFFFE; tbl[2].wide = 64'hFFFFFFFE00000001;
    tbl[3] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 2'b01);
    tbl[3].res = 32'h00000000; tbl[3].wide = 64'h0000000000000001;
    tbl[4] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 2'b11);
    tbl[4].res = 32'hFFFFFFFF; tbl[4].wide = 64'hFFFFFFFF00000001;
    tbl[5] = mk(32'h11223344, 32'hAABBCCDD, 2'b00, 2'b10);
    tbl[5].res = 32'h0B18283A; tbl[5].wide = 64'h0B4A18D628A43AB4;
    tbl[6] = mk(32'h11223344, 32'hAABBCCDD, 2'b11, 2'b01);
    tbl[6].res = 32'h0; tbl[6].ill = 1'b1; tbl[6].wide = 64'h0;
    tbl[7] = mk(32'h80007FFF, 32'hFFFF8001, 2'b01, 2'b11);
    for (int i = 8; i < 18; i++) begin
      tbl[i] = mk($urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    data_in_A = 32'd0; data_in_B = 32'd0; sew = 2'b00; op = 2'b00;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      do_op(tbl[i], (i % 3 == 0) ? 2 : 0);
    end

    // Back-pressure with in_valid held high across the whole operation.
    v27  = mk(32'h89ABCDEF, 32'h12345678, 2'b10, 2'b10);
    v27b = mk(32'h01020304, 32'hF0E0D0C0, 2'b00, 2'b00);
    exp_q.push_back(v27);
    @(negedge clk);
    in_valid = 1'b1; data_in_A = v27.a; data_in_B = v27.b; sew = v27.sew; op = v27.op;
    @(posedge clk); #1;
    exp_q.push_back(v27b);
    data_in_A = v27b.a; data_in_B = v27b.b; sew = v27b.sew; op = v27b.op;
    wait_and_check(4);
    held = result;
    for (int h = 0; h < 3; h++) begin
      check("bp_result", 64'(result), 64'(held));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    check("bp_valid_4th", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_pop_ready", 64'(in_ready), 64'd1);
    check("bp_pop_busy", 64'(busy), 64'd0);
    check("bp_pop_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_accepted", 64'(busy), 64'd1);
    wait_and_check(1);
    pop_check();

    // Reset during the second COMPUTE cycle of a SEW-32 operation.
    v28 = mk(32'hDEADBEEF, 32'hCAFEF00D, 2'b10, 2'b01);
    @(negedge clk);
    in_valid = 1'b1; data_in_A = v28.a; data_in_B = v28.b; sew = v28.sew; op = v28.op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("mid_rst_no_valid", 64'(seen), 64'd0);
    v28b = mk(32'h7F80FF01, 32'h807F01FF, 2'b00, 2'b01);
    do_op(v28b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
